instr_prefetch_queue: RTL and testbench

//  Instruction-fetch front end for the 8-bit/16-bit-instruction core.

---
 rtl/instr_prefetch_queue.sv | 161 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from a handshaked imem into a
// small {PC, instruction} FIFO. Optional zero-latency bypass under `IPQ_BYPASS_EN.
module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_W-1:0]     imem_rdata,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   PC_sel,
    input  logic [ADDR_W-1:0]      branch_target,
    output logic [INSTR_W-1:0]     instruction,
    output logic [ADDR_W-1:0]      PC_out,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [1:0]             state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic redirect;
    logic ack_ok;
    logic q_valid;
    logic bypass;
    logic push;
    logic pop;

    // imem handshake: imem_req rises with imem_addr and both hold until the cycle
    // imem_ack=1, which transfers imem_rdata; only one request is ever outstanding.
    assign redirect = PC_sel | flush;
    assign ack_ok   = (state == REQ) && imem_ack && !redirect;
    assign q_valid  = (count != '0);

`ifdef IPQ_BYPASS_EN
    assign bypass = ack_ok && !q_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed in its ack cycle never enters the queue.
    assign push       = ack_ok && !(bypass && !stall);
    assign pop        = q_valid && !stall && !redirect;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    assign fill_level = count;
    assign state_dbg  = state;

    always_comb begin
        valid       = 1'b0;
        instruction = '0;
        PC_out      = '0;
        if (q_valid) begin
            valid       = 1'b1;
            instruction = q_instr[rd_ptr];
            PC_out      = q_pc[rd_ptr];
        end else if (bypass) begin
            valid       = 1'b1;
            instruction = imem_rdata;
            PC_out      = imem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= imem_addr;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
        end
    end

    // In REQ, fetch_pc equals imem_addr; it only advances once the word is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= branch_target;
                    end else if (count < DEPTH_C) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            imem_req <= 1'b0;
                            fetch_pc <= branch_target;
                            state    <= IDLE;
                        end else begin
                            fetch_pc <= fetch_pc + PC_ONE;
                            if (count_next < DEPTH_C) begin
                                imem_addr <= fetch_pc + PC_ONE;
                            end else begin
                                imem_req <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end else if (redirect) begin
                        fetch_pc <= branch_target;
                        state    <= DROP;
                    end
                end
                DROP: begin
                    if (redirect) fetch_pc <= branch_target;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: two instances (RESET_PC 00 and FE) fed by imem models,
// with a scoreboard monitor comparing every popped head entry against expected queues.
module tb_instr_prefetch_queue;

    localparam int W = 24;
`ifdef IPQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_sel = 1'b0;
    logic [7:0]  target = 8'h00;
    int          lat = 1;

    logic        imem_req    [2];
    logic [7:0]  imem_addr   [2];
    logic        imem_ack    [2];
    logic [15:0] imem_rdata  [2];
    logic [15:0] instruction [2];
    logic [7:0]  pc_out      [2];
    logic        valid       [2];
    logic [2:0]  fill_level  [2];
    logic [1:0]  state_dbg   [2];
    int          wait_cnt    [2];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    instr_prefetch_queue u_dut (
        .clk(clk), .reset(rst_n),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
        .imem_ack(imem_ack[0]), .imem_rdata(imem_rdata[0]),
        .stall(stall), .flush(flush), .PC_sel(pc_sel), .branch_target(target),
        .instruction(instruction[0]), .PC_out(pc_out[0]), .valid(valid[0]),
        .fill_level(fill_level[0]), .state_dbg(state_dbg[0])
    );

    instr_prefetch_queue #(.RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .reset(rst_n),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
        .imem_ack(imem_ack[1]), .imem_rdata(imem_rdata[1]),
        .stall(stall), .flush(flush), .PC_sel(pc_sel), .branch_target(target),
        .instruction(instruction[1]), .PC_out(pc_out[1]), .valid(valid[1]),
        .fill_level(fill_level[1]), .state_dbg(state_dbg[1])
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp0(input logic [7:0] first, input int n);
        logic [7:0] p;
        p = first;
        for (int i = 0; i < n; i++) begin
            exp_q0.push_back({p, word(p)});
            p = p + 8'd1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) step();
        check(name, exp_q0.size() + exp_q1.size(), 0);
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic hold_reset(input logic s);
        rst_n  = 1'b0;
        stall  = s;
        flush  = 1'b0;
        pc_sel = 1'b0;
        target = 8'h00;
        lat    = 1;
        step();
        step();
    endtask

    // Instruction memory: acks a request once it has been pending for lat cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (imem_req[k] && rst_n) begin
                if (wait_cnt[k] >= lat) begin
                    imem_ack[k]   = 1'b1;
                    imem_rdata[k] = word(imem_addr[k]);
                    wait_cnt[k]   = 0;
                end else begin
                    imem_ack[k]   = 1'b0;
                    imem_rdata[k] = 16'hDEAD;
                    wait_cnt[k]   = wait_cnt[k] + 1;
                end
            end else begin
                imem_ack[k]   = 1'b0;
                imem_rdata[k] = 16'hDEAD;
                wait_cnt[k]   = 0;
            end
        end
    end

    // Monitor: every head entry consumed by decode is compared against the expected queue.
    always begin : monitor
        logic [W-1:0] e;
        @(negedge clk);
        #3;
        if (rst_n && !stall && !pc_sel && !flush) begin
            if (valid[0] && exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("pop_dut0", {pc_out[0], instruction[0]}, e);
            end
            if (valid[1] && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("pop_dut_fe", {pc_out[1], instruction[1]}, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_seen;
        logic [7:0] p;

        // Scenario 1 + 5: reset values, sequential streaming, FE->FF->00 wrap
        hold_reset(1'b0);
        check("rst_valid", valid[0], 0);
        check("rst_instr", instruction[0], 0);
        check("rst_pc", pc_out[0], 0);
        check("rst_fill", fill_level[0], 0);
        check("rst_req", imem_req[0], 0);
        check("rst_addr", imem_addr[0], 8'h00);
        check("rst_addr_fe", imem_addr[1], 8'hFE);
        check("rst_state", state_dbg[0], 0);
        check("rst_state_fe", state_dbg[1], 0);
        push_exp0(8'h00, 10);
        p = 8'hFE;
        for (int i = 0; i < 5; i++) begin
            exp_q1.push_back({p, word(p)});
            p = p + 8'd1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !imem_ack[0]; i++) step();
        check("first_ack", imem_ack[0], 1);
        check("ack_cycle_valid", valid[0], BYP);
        step();
        check("post_ack_valid", valid[0], !BYP);
        drain("s1_drain");

        // Scenario 2: stall until full, no requests while full, then resume without loss
        hold_reset(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 60 && fill_level[0] != 3'd4; i++) step();
        check("full_level", fill_level[0], 4);
        req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (imem_req[0]) req_seen++;
        end
        check("full_no_req", req_seen, 0);
        check("full_head_pc", pc_out[0], 8'h00);
        check("full_head_instr", instruction[0], word(8'h00));
        check("full_valid", valid[0], 1);
        push_exp0(8'h00, 8);
        stall = 1'b0;
        drain("s2_drain");

        // Scenario 3: redirect while a slow request is pending
        hold_reset(1'b1);
        lat   = 3;
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !imem_req[0]; i++) step();
        check("s3_req_up", imem_req[0], 1);
        pc_sel = 1'b1;
        target = 8'h40;
        step();
        pc_sel = 1'b0;
        check("s3_drop_state", state_dbg[0], 2);
        check("s3_req_held", imem_req[0], 1);
        check("s3_addr_held", imem_addr[0], 8'h00);
        for (int i = 0; i < 30 && !(imem_req[0] && imem_addr[0] == 8'h40); i++) step();
        check("s3_refetch_addr", imem_addr[0], 8'h40);
        check("s3_fill_empty", fill_level[0], 0);
        push_exp0(8'h40, 3);
        stall = 1'b0;
        drain("s3_drain");

        // Scenario 4: flush coincident with an ack
        hold_reset(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && !(imem_ack[0] && fill_level[0] == 3'd2); i++) step();
        check("s4_ack_at_2", fill_level[0], 2);
        flush  = 1'b1;
        target = 8'h80;
        step();
        flush = 1'b0;
        check("s4_valid_off", valid[0], 0);
        check("s4_fill_off", fill_level[0], 0);
        check("s4_req_off", imem_req[0], 0);
        for (int i = 0; i < 10 && !imem_req[0]; i++) step();
        check("s4_refetch_addr", imem_addr[0], 8'h80);
        push_exp0(8'h80, 3);
        stall = 1'b0;
        drain("s4_drain");

        // Scenario 6: asynchronous reset in the middle of a request with 3 entries queued
        hold_reset(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && !(fill_level[0] == 3'd3 && imem_req[0]); i++) step();
        check("s6_pre_fill", fill_level[0], 3);
        rst_n = 1'b0;
        #1;
        check("s6_valid", valid[0], 0);
        check("s6_instr", instruction[0], 0);
        check("s6_pc", pc_out[0], 0);
        check("s6_fill", fill_level[0], 0);
        check("s6_req", imem_req[0], 0);
        check("s6_addr", imem_addr[0], 8'h00);
        check("s6_addr_fe", imem_addr[1], 8'hFE);
        step();
        push_exp0(8'h00, 3);
        stall = 1'b0;
        rst_n = 1'b1;
        drain("s6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
